// File: rtl/riscv_run_ctrl.sv
// Run controller for a RISC-V core behind an AXI4-Lite slave: loads imem,
// sequences core reset, gates execution under a cycle budget and reports status.
module riscv_run_ctrl #(
  parameter int IMEM_AW    = 10,
  parameter int RST_CYCLES = 4
) (
  input  logic               s00_axi_aclk,
  input  logic               s00_axi_aresetn,
  input  logic               i_mem_reset_n,
  input  logic               i_run_pc_in,
  input  logic [31:0]        i_slv_reg1,
  input  logic [31:0]        i_slv_reg2,
  input  logic [31:0]        i_slv_reg3,
  input  logic               i_core_halt,
  input  logic [31:0]        i_core_pc,
  output logic               o_core_rst_n,
  output logic               o_core_en,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_wdata,
  output logic [31:0]        o_status,
  output logic [31:0]        o_cycle_cnt,
  output logic [31:0]        o_last_pc,
  output logic               o_done_irq
);

  // state    | meaning
  // MEMRST   | software memory reset held; core in reset, flags cleared
  // IDLE     | imem loads accepted; waiting for a run rising edge
  // CORE_RST | core reset held for RST_CYCLES cycles
  // RUN      | core enabled, cycles counted against the budget
  // DONE     | run finished; core frozen for debug, cause reported
  typedef enum logic [2:0] {
    MEMRST   = 3'd0,
    IDLE     = 3'd1,
    CORE_RST = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_e             state_q;
  logic               tog_q, run_q;
  logic [RCW-1:0]     rst_cnt_q;
  logic [31:0]        budget_q, cnt_q, last_pc_q, wdata_q;
  logic [IMEM_AW-1:0] addr_q;
  logic               done_q, halted_q, timeout_q, aborted_q, dropped_q;
  logic               we_q, irq_q, core_rst_n_q, core_en_q;

  logic        tog_evt, run_rise, timeout_hit, exit_run;
  logic [31:0] cnt_d;
  logic        unused_reg1;

  assign tog_evt     = i_slv_reg1[31] != tog_q;
  assign run_rise    = i_run_pc_in & ~run_q;
  assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + 32'd1;
  // 33-bit compare so a saturated counter can never alias a small budget
  assign timeout_hit = (budget_q != 32'd0) && (({1'b0, cnt_q} + 33'd1) == {1'b0, budget_q});
  assign exit_run    = i_core_halt | timeout_hit | ~i_run_pc_in;
  assign unused_reg1 = ^i_slv_reg1[30:IMEM_AW];

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      state_q      <= MEMRST;
      tog_q        <= 1'b0;
      run_q        <= 1'b0;
      rst_cnt_q    <= '0;
      budget_q     <= '0;
      cnt_q        <= '0;
      last_pc_q    <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      done_q       <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      aborted_q    <= 1'b0;
      dropped_q    <= 1'b0;
      we_q         <= 1'b0;
      irq_q        <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
    end else begin
      tog_q <= i_slv_reg1[31];
      run_q <= i_run_pc_in;
      we_q  <= 1'b0;
      irq_q <= 1'b0;
      if (!i_mem_reset_n) begin
        state_q      <= MEMRST;
        core_rst_n_q <= 1'b0;
        core_en_q    <= 1'b0;
        cnt_q        <= '0;
        done_q       <= 1'b0;
        halted_q     <= 1'b0;
        timeout_q    <= 1'b0;
        aborted_q    <= 1'b0;
        dropped_q    <= 1'b0;
      end else begin
        case (state_q)
          MEMRST: begin
            state_q      <= IDLE;
            core_rst_n_q <= 1'b1;
          end
          IDLE, DONE: begin
            if (tog_evt) begin
              if (state_q == IDLE) begin
                we_q    <= 1'b1;
                addr_q  <= i_slv_reg1[IMEM_AW-1:0];
                wdata_q <= i_slv_reg2;
              end else begin
                dropped_q <= 1'b1;
              end
            end
            if (run_rise) begin
              state_q      <= CORE_RST;
              rst_cnt_q    <= RCW'(RST_CYCLES - 1);
              core_rst_n_q <= 1'b0;
              core_en_q    <= 1'b0;
              cnt_q        <= '0;
              done_q       <= 1'b0;
              halted_q     <= 1'b0;
              timeout_q    <= 1'b0;
              aborted_q    <= 1'b0;
            end
          end
          CORE_RST: begin
            if (tog_evt) dropped_q <= 1'b1;
            if (rst_cnt_q == '0) begin
              state_q      <= RUN;
              core_rst_n_q <= 1'b1;
              core_en_q    <= 1'b1;
              budget_q     <= i_slv_reg3;
            end else begin
              rst_cnt_q <= rst_cnt_q - RCW'(1);
            end
          end
          RUN: begin
            if (tog_evt) dropped_q <= 1'b1;
            cnt_q <= cnt_d;
            if (exit_run) begin
              state_q   <= DONE;
              core_en_q <= 1'b0;
              done_q    <= 1'b1;
              irq_q     <= 1'b1;
              last_pc_q <= i_core_pc;
              halted_q  <= i_core_halt;
              timeout_q <= ~i_core_halt & timeout_hit;
              aborted_q <= ~i_core_halt & ~timeout_hit;
            end
          end
          default: state_q <= MEMRST;
        endcase
      end
    end
  end

  assign o_core_rst_n = core_rst_n_q;
  assign o_core_en    = core_en_q;
  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_status     = {24'd0, dropped_q, aborted_q, timeout_q, halted_q, done_q, state_q};
  assign o_cycle_cnt  = cnt_q;
  assign o_last_pc    = last_pc_q;
  assign o_done_irq   = irq_q;

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Randomized bench for riscv_run_ctrl: run outcomes are predicted per run from
// budget / halt / abort cycle numbers and compared against the DUT.
module tb_riscv_run_ctrl;
  localparam int AW = 10;
  localparam int RC = 4;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          mem_reset_n = 1'b0;
  logic          run = 1'b0;
  logic [31:0]   slv_reg1 = '0, slv_reg2 = '0, slv_reg3 = '0;
  logic          core_halt = 1'b0;
  logic [31:0]   core_pc = '0;
  logic          core_rst_n, core_en, imem_we, done_irq;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata, status, cycle_cnt, last_pc;

  riscv_run_ctrl #(.IMEM_AW(AW), .RST_CYCLES(RC)) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(aresetn), .i_mem_reset_n(mem_reset_n),
    .i_run_pc_in(run), .i_slv_reg1(slv_reg1), .i_slv_reg2(slv_reg2), .i_slv_reg3(slv_reg3),
    .i_core_halt(core_halt), .i_core_pc(core_pc), .o_core_rst_n(core_rst_n),
    .o_core_en(core_en), .o_imem_we(imem_we), .o_imem_addr(imem_addr),
    .o_imem_wdata(imem_wdata), .o_status(status), .o_cycle_cnt(cycle_cnt),
    .o_last_pc(last_pc), .o_done_irq(done_irq)
  );

  always #5 clk = ~clk;

  int   n_chk = 0, n_pass = 0;
  logic tog = 1'b0;
  logic ld_exp = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
    int          we_n = 0;
    logic [31:0] ga = '0, gd = '0;
    tog      = ~tog;
    slv_reg1 = {tog, {(31-AW){1'b0}}, a};
    slv_reg2 = d;
    repeat (4) begin
      @(negedge clk);
      if (imem_we) begin
        we_n++;
        ga = 32'(imem_addr);
        gd = imem_wdata;
      end
    end
    check("load_we_pulses", we_n, 1);
    check("load_addr", ga, 32'(a));
    check("load_wdata", gd, d);
    check("load_state_idle", status, {24'd0, ld_exp, 7'd1});
  endtask

  // b: budget, h: RUN cycle halt rises (0 none), a: RUN cycle run drops (0 none),
  // dr: RUN cycle slv_reg1[31] flips (0 none)
  task automatic run_case(input logic [31:0] b, input int h, input int a, input int dr);
    int   e = 0, k = 0, rl = 0, irq_n = 0, we_n = 0;
    logic hl, to, ab, fin = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if ((h != 0 && c >= h) || (b != 0 && c == int'(b)) || (a != 0 && c >= a)) begin
        e = c;
        break;
      end
    end
    hl = (h != 0) && (e >= h);
    to = !hl && (int'(b) == e);
    ab = !hl && !to;
    if (dr != 0 && dr <= e) ld_exp = 1'b1;

    slv_reg3  = b;
    core_halt = 1'b0;
    run       = 1'b1;
    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if (!core_rst_n) rl++;
      if (imem_we) we_n++;
      if (done_irq) irq_n++;
      if (status[2:0] == 3'd4) begin
        fin = 1'b1;
        break;
      end
      if (core_en) begin
        k++;
        core_halt = (h != 0) && (k >= h);
        core_pc   = 32'h1000 + 32'(4 * k);
        if (a != 0 && k >= a) run = 1'b0;
        if (k == dr) begin
          tog      = ~tog;
          slv_reg1 = {tog, slv_reg1[30:0]};
        end
      end
    end
    if (!fin) check("run_reached_done", 32'd0, 32'd1);
    check("run_core_en_off", 32'(core_en), 32'd0);
    core_halt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done_irq) irq_n++;
    end
    check("run_rst_low_cycles", rl, RC);
    check("run_en_cycles", k, e);
    check("run_cycle_cnt", cycle_cnt, 32'(e));
    check("run_status", status, {24'd0, ld_exp, ab, to, hl, 1'b1, 3'd4});
    check("run_last_pc", last_pc, 32'h1000 + 32'(4 * e));
    check("run_irq_pulses", irq_n, 1);
    check("run_no_imem_we", we_n, 0);
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_run_cycles(input int n);
    int k = 0;
    for (int it = 0; it < 200 && k < n; it++) begin
      @(negedge clk);
      if (core_en) k++;
    end
    if (k < n) check("wait_run_cycles", k, n);
  endtask

  initial begin
    #2;
    check("rst_status", status, 32'd0);
    check("rst_core_rst_n", 32'(core_rst_n), 32'd0);
    check("rst_core_en", 32'(core_en), 32'd0);
    check("rst_we_irq", {30'd0, imem_we, done_irq}, 32'd0);
    check("rst_cnt_pc", cycle_cnt | last_pc, 32'd0);

    @(negedge clk);
    aresetn = 1'b1;
    @(negedge clk);
    check("memrst_hold", status, 32'd0);
    mem_reset_n = 1'b1;
    @(negedge clk);
    check("memrst_to_idle", status, 32'd1);

    do_load(10'h005, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) do_load(AW'($urandom), $urandom);

    run_case(32'd0, 11, 0, 0);
    run_case(32'd100, 0, 0, 0);
    run_case(32'd20, 20, 0, 0);
    run_case(32'd0, 0, 15, 7);
    for (int i = 0; i < 6; i++) begin
      int rb, rh, ra, rd;
      rb = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0;
      rh = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : 0;
      ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 40)) : 0;
      rd = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      if (rb == 0 && rh == 0 && ra == 0) rh = int'($urandom_range(1, 40));
      run_case(32'(rb), rh, ra, rd);
    end

    slv_reg3 = 32'd0;
    run = 1'b1;
    wait_run_cycles(5);
    mem_reset_n = 1'b0;
    ld_exp = 1'b0;
    @(negedge clk);
    check("mr_status", status, 32'd0);
    check("mr_core_rst_n", 32'(core_rst_n), 32'd0);
    check("mr_core_en", 32'(core_en), 32'd0);
    check("mr_cycle_cnt", cycle_cnt, 32'd0);
    mem_reset_n = 1'b1;
    run = 1'b0;
    @(negedge clk);
    check("mr_back_idle", status, 32'd1);
    check("mr_idle_rst_n", 32'(core_rst_n), 32'd1);

    run = 1'b1;
    wait_run_cycles(3);
    aresetn = 1'b0;
    #1;
    check("ar_status", status, 32'd0);
    check("ar_core", {30'd0, core_rst_n, core_en}, 32'd0);
    check("ar_cnt", cycle_cnt, 32'd0);
    check("ar_last_pc", last_pc, 32'd0);
    check("ar_we_irq", {30'd0, imem_we, done_irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_run_ctrl.md
Name: riscv_run_ctrl

Overview:
- Run controller for the RISC-V core behind the AXI4-Lite slave; driven by the slave's user registers (mem reset, run, slv_reg1..3).
- Sequences instruction-memory loading, holds and releases core reset, and gates core execution under a cycle budget.
- Reports state, stop cause, cycle count and final PC for software readback, plus a done interrupt.

Parameters:
IMEM_AW, 10, instruction-memory word-address width
RST_CYCLES, 4, cycles core reset is held before a run (≥1)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
i_mem_reset_n  in  1  software memory/controller reset level, active-low
i_run_pc_in  in  1  software run level; rising edge starts a run, falling edge aborts
i_slv_reg1  in  32  [IMEM_AW-1:0] imem word address; [31] write toggle
i_slv_reg2  in  32  imem write data
i_slv_reg3  in  32  run cycle budget; 0 = unlimited
i_core_halt  in  1  core halted (ebreak/ecall), level
i_core_pc  in  32  core current PC
o_core_rst_n  out  1  core reset, active-low
o_core_en  out  1  core clock enable
o_imem_we  out  1  imem write strobe
o_imem_addr  out  IMEM_AW  imem write address
o_imem_wdata  out  32  imem write data
o_status  out  32  [2:0] state, [3] done, [4] halted, [5] timeout, [6] aborted, [7] load_dropped, rest 0
o_cycle_cnt  out  32  cycles spent in RUN
o_last_pc  out  32  PC captured on RUN exit
o_done_irq  out  1  one-cycle pulse on DONE entry

Behaviour:
- Async reset: state MEMRST(0); o_core_rst_n=0, o_core_en=0, o_imem_we=0, addr/wdata=0, status flags=0, o_cycle_cnt=0, o_last_pc=0, o_done_irq=0; toggle and run edge trackers = 0.
- States (encoding in o_status[2:0]): MEMRST=0, IDLE=1, CORE_RST=2, RUN=3, DONE=4.
- i_mem_reset_n=0 in any state -> MEMRST next cycle; overrides all else. MEMRST: core_rst_n=0, core_en=0, all sticky flags and cycle_cnt cleared. Leaves to IDLE the cycle after i_mem_reset_n=1.
- Load: toggle event = i_slv_reg1[31] != tracker. Tracker updates every cycle in every state. Event in IDLE at cycle t: addr/wdata captured from slv_reg1/slv_reg2 at t; o_imem_we=1 at t+1 for exactly one cycle. Event in any other state: no write; load_dropped sticky set (except MEMRST, which is silent).
- Run edge: rising edge of i_run_pc_in (registered tracker) in IDLE or DONE -> CORE_RST; clears cycle_cnt, done/halted/timeout/aborted. Ignored in MEMRST, CORE_RST, RUN. Run edge and load event in the same IDLE cycle: load write still issued, then CORE_RST.
- CORE_RST: core_rst_n=0, core_en=0 for exactly RST_CYCLES cycles, then RUN.
- RUN: core_rst_n=1, core_en=1; cycle_cnt +1 per RUN cycle, saturating at 0xFFFFFFFF. Exit to DONE, checked each cycle with priority halt > timeout > abort:
  - i_core_halt=1 -> halted
  - budget≠0 and cycle_cnt+1 == budget (this cycle is the budget-th) -> timeout; cycle_cnt ends equal to budget
  - i_run_pc_in=0 -> aborted
  - budget is sampled on RUN entry; later slv_reg3 writes have no effect until the next run.
- DONE: core_en=0, core_rst_n=1 (state held for debug); done=1; o_last_pc = i_core_pc from the exit cycle; o_done_irq high on the first DONE cycle only. Stays until a run rising edge or mem reset.
- Exit cycle counts as a RUN cycle: halt on the 1st RUN cycle gives cycle_cnt=1.
- o_status/o_cycle_cnt/o_last_pc are registered and readable in every state.

Test Plan:
- Release reset, i_mem_reset_n 0->1; flip slv_reg1[31] with addr=0x005, data=0xDEADBEEF -> one o_imem_we pulse, addr 0x005, wdata 0xDEADBEEF, state IDLE(1).
- i_run_pc_in 0->1, budget 0, i_core_halt raised after 10 RUN cycles -> core_rst_n low exactly 4 cycles, then cycle_cnt=11, status halted+done, single done_irq pulse, o_last_pc = PC at halt.
- Budget=100, no halt -> DONE after exactly 100 RUN cycles, cycle_cnt=100, timeout=1; halt and timeout in the same cycle -> halted=1, timeout=0.
- Drop i_run_pc_in mid-run -> aborted=1, core_en=0 next cycle; flip toggle during RUN -> no imem_we, load_dropped=1.
- Pull i_mem_reset_n low during RUN -> MEMRST next cycle, core_rst_n=0, flags and cycle_cnt cleared; assert s00_axi_aresetn mid-run -> all outputs at reset values immediately, without waiting for a clock edge.
